edge_player: RTL and testbench

- Replays a stream of posedge timestamps, in units of `clock` cycles since `enable` first rose, as a regenerated clock waveform.
- Hardware/testbench counterpart to the edge-time writer: a file loader or host link pushes timestamps in; the block emits `edge_pulse` and `clk_out` at those times.
- Used to drive PLL/DCO consumers with recorded edge sequences and to check timestamp streams for ordering errors.

---
 rtl/edge_player_if.sv | 15 +
 rtl/edge_player.sv | 146 ++++++++++++++
 tb/tb_edge_player.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_player_if.sv
// edge_player_if: timestamp push channel into edge_player.
//   ts_valid  producer offers a timestamp
//   ts_ready  consumer can accept (FIFO not full)
//   ts_data   absolute edge time in clock cycles
// Modports: master = timestamp producer, slave = edge_player.
interface edge_player_if #(
  parameter int TS_W = 32
);
  logic            ts_valid;
  logic            ts_ready;
  logic [TS_W-1:0] ts_data;

  modport master (output ts_valid, output ts_data, input ts_ready);
  modport slave  (input ts_valid, input ts_data, output ts_ready);
endinterface

// File: rtl/edge_player.sv
// edge_player: replays queued posedge timestamps (cycles since enable first
// rose) as a regenerated clock waveform.
// Ports:
//   clock, reset    block clock; asynchronous active-high reset
//   enable          advances the time counter and allows playback
//   ts (slave)      timestamp push channel (ts_valid/ts_ready/ts_data)
//   edge_pulse      one-cycle pulse per played edge
//   clk_out         regenerated clock, HIGH_CYCLES enabled cycles per edge
//   edge_count      number of edges played (wraps)
//   late            sticky: a timestamp was discarded as already past
//   overlap         sticky: an edge played while clk_out was still high
// Optional macro EDGE_PLAYER_STATS_EN adds min_interval/max_interval,
// the min/max spacing in cycles between consecutive played edges.
module edge_player #(
  parameter int TS_W        = 32,
  parameter int DEPTH       = 4,
  parameter int HIGH_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  edge_player_if.slave    ts,
  output logic            edge_pulse,
  output logic            clk_out,
  output logic [TS_W-1:0] edge_count,
  output logic            late,
  output logic            overlap
`ifdef EDGE_PLAYER_STATS_EN
  ,
  output logic [TS_W-1:0] min_interval,
  output logic [TS_W-1:0] max_interval
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int HC_W = (HIGH_CYCLES > 1) ? $clog2(HIGH_CYCLES) : 1;
  localparam logic [HC_W-1:0] HC_LOAD = HC_W'(HIGH_CYCLES - 1);

  logic [TS_W-1:0] mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [TS_W-1:0] now;
  logic [HC_W-1:0] hcnt;

  logic            full;
  logic            empty;
  logic            push;
  logic [TS_W-1:0] head;
  logic            match_p0;
  logic            stale_p0;
  logic            pop;

  // Stage 0: FIFO status and head-versus-now comparison
  // Extra pointer MSB distinguishes full from empty when indices coincide.
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);
  assign ts.ts_ready = !full;
  // Ready depends only on full, so a pop in a full cycle cannot admit a push.
  assign push  = ts.ts_valid && !full;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign match_p0 = enable && !empty && (head == now);
  assign stale_p0 = enable && !empty && (head < now);
  assign pop      = match_p0 || stale_p0;

  // Timestamp storage is pure data and carries no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= ts.ts_data;
    end
  end

  // Stage 1: registered playback state and outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      now        <= '0;
      hcnt       <= '0;
      edge_pulse <= 1'b0;
      clk_out    <= 1'b0;
      edge_count <= '0;
      late       <= 1'b0;
      overlap    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (enable) begin
        now <= now + TS_W'(1);
      end
      edge_pulse <= match_p0;
      if (match_p0) begin
        // A match while still high stretches the pulse from this edge.
        clk_out    <= 1'b1;
        hcnt       <= HC_LOAD;
        edge_count <= edge_count + TS_W'(1);
        if (clk_out) begin
          overlap <= 1'b1;
        end
      end else if (enable && clk_out) begin
        if (hcnt == '0) begin
          clk_out <= 1'b0;
        end else begin
          hcnt <= hcnt - HC_W'(1);
        end
      end
      if (stale_p0) begin
        late <= 1'b1;
      end
    end
  end

`ifdef EDGE_PLAYER_STATS_EN
  logic [TS_W-1:0] prev_edge;
  logic            have_prev;
  logic [TS_W-1:0] interval;

  assign interval = now - prev_edge;

  // Stage 1: edge-to-edge interval statistics (first edge only seeds prev_edge)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_edge    <= '0;
      have_prev    <= 1'b0;
      min_interval <= '1;
      max_interval <= '0;
    end else if (match_p0) begin
      prev_edge <= now;
      have_prev <= 1'b1;
      if (have_prev) begin
        if (interval < min_interval) begin
          min_interval <= interval;
        end
        if (interval > max_interval) begin
          max_interval <= interval;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_edge_player.sv
// tb_edge_player: directed bench for edge_player (TS_W=32, DEPTH=4,
// HIGH_CYCLES=2). A per-cycle vector table covers basic playback, late
// duplicates and enable gating; hand-written sequences cover multi-cycle
// corner cases. tnow tracks the DUT time value visible after each edge.
module tb_edge_player;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        edge_pulse;
  logic        clk_out;
  logic [31:0] edge_count;
  logic        late;
  logic        overlap;
`ifdef EDGE_PLAYER_STATS_EN
  logic [31:0] min_interval;
  logic [31:0] max_interval;
`endif

  edge_player_if #(.TS_W(32)) bus ();

  edge_player #(.TS_W(32), .DEPTH(4), .HIGH_CYCLES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .ts         (bus),
    .edge_pulse (edge_pulse),
    .clk_out    (clk_out),
    .edge_count (edge_count),
    .late       (late),
    .overlap    (overlap)
`ifdef EDGE_PLAYER_STATS_EN
    ,
    .min_interval (min_interval),
    .max_interval (max_interval)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic        vld;
    logic [31:0] data;
    logic        ready;
    logic        pulse;
    logic        clk;
    logic [31:0] cnt;
    logic        late;
    logic        ovl;
  } vec_t;

  vec_t vt[13];
  int   n_chk;
  int   n_fail;
  int   tnow;
  int   hi_cnt;
  int   pulse_q[$];
  int   idx;
  logic rdy;

  function automatic vec_t mk(logic en, logic vld, logic [31:0] data, logic ready,
                              logic pulse, logic clk, logic [31:0] cnt, logic lt, logic ovl);
    vec_t v;
    v.en = en; v.vld = vld; v.data = data; v.ready = ready; v.pulse = pulse;
    v.clk = clk; v.cnt = cnt; v.late = lt; v.ovl = ovl;
    return v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_pulse(input string nm, input int i, input int exp);
    if (i < pulse_q.size()) begin
      chk(nm, pulse_q[i], exp);
    end else begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no pulse recorded, expected pulse at now=%0d", nm, exp);
    end
  endtask

  // Drive inputs, take one clock edge, then observe 1 time unit later.
  task automatic step(input logic en, input logic vld, input logic [31:0] d);
    enable      = en;
    bus.ts_valid = vld;
    bus.ts_data  = d;
    @(posedge clock);
    if (en) tnow++;
    #1;
    if (edge_pulse) pulse_q.push_back(tnow);
    if (en && clk_out) hi_cnt++;
  endtask

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) step(en, 1'b0, 32'd0);
  endtask

  task automatic clear_obs();
    pulse_q.delete();
    hi_cnt = 0;
  endtask

  task automatic do_reset();
    enable       = 1'b0;
    bus.ts_valid = 1'b0;
    bus.ts_data  = '0;
    reset        = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    tnow  = 0;
    clear_obs();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    tnow   = 0;
    hi_cnt = 0;
    reset        = 1'b1;
    enable       = 1'b0;
    bus.ts_valid = 1'b0;
    bus.ts_data  = '0;

    vt[0]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 4, 1, 0, 0, 0, 0, 0);
    vt[2]  = mk(1, 1, 4, 1, 0, 0, 0, 0, 0);
    vt[3]  = mk(1, 0, 0, 1, 1, 1, 1, 0, 0);
    vt[4]  = mk(1, 0, 0, 1, 0, 1, 1, 0, 0);
    vt[5]  = mk(1, 0, 0, 1, 0, 0, 1, 0, 0);
    vt[6]  = mk(1, 0, 0, 1, 1, 1, 2, 0, 0);
    vt[7]  = mk(1, 0, 0, 1, 0, 1, 2, 1, 0);
    vt[8]  = mk(1, 0, 0, 1, 0, 0, 2, 1, 0);
    vt[9]  = mk(0, 0, 0, 1, 0, 0, 2, 1, 0);
    vt[10] = mk(1, 1, 9, 1, 0, 0, 2, 1, 0);
    vt[11] = mk(1, 0, 0, 1, 0, 0, 2, 1, 0);
    vt[12] = mk(1, 0, 0, 1, 1, 1, 3, 1, 0);

    // Reset values, observed before the first clock edge.
    #3;
    chk("rst_ready", bus.ts_ready, 1);
    chk("rst_pulse", edge_pulse, 0);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_count", edge_count, 0);
    chk("rst_late", late, 0);
    chk("rst_overlap", overlap, 0);
`ifdef EDGE_PLAYER_STATS_EN
    chk("rst_min", min_interval, 64'hFFFF_FFFF);
    chk("rst_max", max_interval, 0);
`endif
    do_reset();

    // Vector table: edges at 1 and 4, duplicate 4 is late, then edge at 9.
    for (int i = 0; i < 13; i++) begin
      step(vt[i].en, vt[i].vld, vt[i].data);
      chk($sformatf("vec%0d_ready", i), bus.ts_ready, vt[i].ready);
      chk($sformatf("vec%0d_pulse", i), edge_pulse, vt[i].pulse);
      chk($sformatf("vec%0d_clk_out", i), clk_out, vt[i].clk);
      chk($sformatf("vec%0d_count", i), edge_count, vt[i].cnt);
      chk($sformatf("vec%0d_late", i), late, vt[i].late);
      chk($sformatf("vec%0d_overlap", i), overlap, vt[i].ovl);
    end

    // Basic playback: 5, 10, 20 pushed before enable.
    do_reset();
    step(0, 1, 5);
    step(0, 1, 10);
    step(0, 1, 20);
    clear_obs();
    run(25, 1'b1);
    chk("basic_npulses", pulse_q.size(), 3);
    chk_pulse("basic_p0", 0, 6);
    chk_pulse("basic_p1", 1, 11);
    chk_pulse("basic_p2", 2, 21);
    chk("basic_high_cycles", hi_cnt, 6);
    chk("basic_count", edge_count, 3);
    chk("basic_late", late, 0);
    chk("basic_overlap", overlap, 0);
`ifdef EDGE_PLAYER_STATS_EN
    chk("basic_min", min_interval, 5);
    chk("basic_max", max_interval, 10);
`endif

    // Non-monotonic: 10 then 8; 8 is discarded as late.
    do_reset();
    step(0, 1, 10);
    step(0, 1, 8);
    clear_obs();
    run(15, 1'b1);
    chk("late_npulses", pulse_q.size(), 1);
    chk_pulse("late_p0", 0, 11);
    chk("late_flag", late, 1);
    chk("late_count", edge_count, 1);

    // Overlap: edges 10 and 11 with 2-cycle high time stretch clk_out.
    do_reset();
    step(0, 1, 10);
    step(0, 1, 11);
    clear_obs();
    run(16, 1'b1);
    chk("ovl_npulses", pulse_q.size(), 2);
    chk_pulse("ovl_p0", 0, 11);
    chk_pulse("ovl_p1", 1, 12);
    chk("ovl_high_cycles", hi_cnt, 3);
    chk("ovl_flag", overlap, 1);
    chk("ovl_count", edge_count, 2);
`ifdef EDGE_PLAYER_STATS_EN
    chk("ovl_min", min_interval, 1);
    chk("ovl_max", max_interval, 1);
`endif

    // Full FIFO: hold valid with 100..107 while disabled, then play.
    do_reset();
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      rdy = bus.ts_ready;
      step(0, 1, 32'(100 + idx));
      if (rdy) idx++;
    end
    chk("full_accepted", idx, 4);
    chk("full_ready", bus.ts_ready, 0);
    clear_obs();
    for (int c = 0; c < 115; c++) begin
      rdy = bus.ts_ready;
      if (idx < 8) begin
        step(1, 1, 32'(100 + idx));
        if (rdy) idx++;
      end else begin
        step(1, 0, 32'd0);
      end
    end
    chk("full_all_accepted", idx, 8);
    chk("full_npulses", pulse_q.size(), 8);
    for (int i = 0; i < 8; i++) chk_pulse($sformatf("full_p%0d", i), i, 101 + i);
    chk("full_count", edge_count, 8);
    chk("full_late", late, 0);
    chk("full_overlap", overlap, 1);

    // Enable pause with head 9 pending, then pause while clk_out is high.
    do_reset();
    step(0, 1, 9);
    clear_obs();
    run(7, 1'b1);
    run(5, 1'b0);
    run(3, 1'b1);
    chk("pause_npulses", pulse_q.size(), 1);
    chk_pulse("pause_p0", 0, 10);
    run(3, 1'b0);
    chk("pause_clk_frozen", clk_out, 1);
    run(3, 1'b1);
    chk("pause_high_cycles", hi_cnt, 2);
    chk("pause_clk_low", clk_out, 0);
    chk("pause_count", edge_count, 1);

    // Reset mid-playback with clk_out high and 3 entries queued.
    do_reset();
    step(0, 1, 3);
    step(0, 1, 10);
    step(0, 1, 11);
    step(0, 1, 12);
    clear_obs();
    run(4, 1'b1);
    chk("midrst_pre_clk", clk_out, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_pulse", edge_pulse, 0);
    chk("midrst_clk_out", clk_out, 0);
    chk("midrst_count", edge_count, 0);
    chk("midrst_ready", bus.ts_ready, 1);
    chk("midrst_late", late, 0);
    chk("midrst_overlap", overlap, 0);
`ifdef EDGE_PLAYER_STATS_EN
    chk("midrst_min", min_interval, 64'hFFFF_FFFF);
    chk("midrst_max", max_interval, 0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
    tnow  = 0;
    clear_obs();
    run(20, 1'b1);
    chk("midrst_npulses", pulse_q.size(), 0);
    chk("midrst_count_after", edge_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
